// File: rtl/mips_alu_pkg.sv
// ---------------------------------------------------------------------------
// mips_alu_pkg
// Shared definitions for the execute-stage ALU: the op-class encoding carried
// in alufun[5:4], the full 6-bit function codes, and a helper that extracts
// the class from a function code.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_alu_pkg;

    localparam int ALU_WIDTH = 32;

    // Op class lives in the top two bits of the function code
    typedef enum logic [1:0] {
        ALU_ARITH = 2'b00,
        ALU_LOGIC = 2'b01,
        ALU_SHIFT = 2'b10,
        ALU_CMP   = 2'b11
    } alu_class_e;

    // Full function codes; the decoder matches on the relevant slices of these
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b011000;
    localparam logic [5:0] OP_OR    = 6'b011110;
    localparam logic [5:0] OP_XOR   = 6'b010110;
    localparam logic [5:0] OP_NOR   = 6'b010001;
    localparam logic [5:0] OP_PASSA = 6'b011010;
    localparam logic [5:0] OP_SLL   = 6'b100000;
    localparam logic [5:0] OP_SRL   = 6'b100001;
    localparam logic [5:0] OP_SRA   = 6'b100011;
    localparam logic [5:0] OP_EQ    = 6'b110011;
    localparam logic [5:0] OP_NEQ   = 6'b110001;
    localparam logic [5:0] OP_LT    = 6'b110101;
    localparam logic [5:0] OP_LEZ   = 6'b111101;
    localparam logic [5:0] OP_LTZ   = 6'b111011;
    localparam logic [5:0] OP_GTZ   = 6'b111111;

    function automatic alu_class_e getClass(input logic [5:0] fun);
        return alu_class_e'(fun[5:4]);
    endfunction

endpackage

// File: rtl/mips_alu_if.sv
// ---------------------------------------------------------------------------
// mips_alu_if
// Operand/result bundle between the operand muxes and the ALU.
//   a      : operand A, also supplies the shift amount a[4:0]
//   b      : operand B, the value being shifted
//   alufun : 6-bit function code
//   sign   : 1 = signed compare/overflow semantics
//   res    : registered result
// master = producer of operands (datapath / bench), slave = the ALU.
// ---------------------------------------------------------------------------
interface mips_alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [5:0]       alufun;
    logic             sign;
    logic [WIDTH-1:0] res;

    modport master (output a, output b, output alufun, output sign, input res);
    modport slave  (input a, input b, input alufun, input sign, output res);
endinterface

// File: rtl/mips_alu_adder.sv
// ---------------------------------------------------------------------------
// mips_alu_adder
// Combinational add/subtract shared by the arithmetic and compare classes.
//   i_a, i_b : operands
//   i_sub    : 1 = a - b (as a + ~b + 1), 0 = a + b
//   i_sign   : selects how o_n is formed
//   o_sum    : wrapped sum/difference
//   o_z      : sum is zero
//   o_v      : signed overflow
//   o_n      : "a < b" flag after a subtract: sum[msb]^V when signed,
//              unsigned borrow otherwise
// ---------------------------------------------------------------------------
module mips_alu_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_z,
    output logic             o_v,
    output logic             o_n
);

    logic [WIDTH-1:0] w_bEff;
    logic [WIDTH:0]   w_full;
    logic             w_borrow;

    assign w_bEff = i_sub ? ~i_b : i_b;
    assign w_full = {1'b0, i_a} + {1'b0, w_bEff} + {{WIDTH{1'b0}}, i_sub};
    assign o_sum  = w_full[WIDTH-1:0];
    assign o_z    = (o_sum == '0);

    // Overflow: both addends share a sign and the sum's sign differs
    assign o_v = (i_a[WIDTH-1] == w_bEff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

    // With a + ~b + 1, a missing carry-out means a borrow (a < b unsigned)
    assign w_borrow = i_sub & ~w_full[WIDTH];

    assign o_n = i_sign ? (o_sum[WIDTH-1] ^ o_v) : w_borrow;

endmodule

// File: rtl/mips_alu.sv
// ---------------------------------------------------------------------------
// mips_alu
// 32-bit execute-stage ALU with a registered result (one-cycle latency).
//   clk    : rising-edge clock
//   reset  : synchronous active-high, clears res
//   aluBus : slave side of mips_alu_if (a, b, alufun, sign in; res out)
// The class in alufun[5:4] selects arithmetic, logic, shift or compare.
// ---------------------------------------------------------------------------
module mips_alu
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    mips_alu_if.slave   aluBus
);

    alu_class_e       w_class;
    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_z;
    logic             w_v;
    logic             w_n;
    logic             w_unusedFlags;
    logic [4:0]       w_shamt;
    logic [WIDTH-1:0] w_logicRes;
    logic [WIDTH-1:0] w_shiftRes;
    logic             w_aZero;
    logic             w_cond;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_res;

    assign w_class = getClass(aluBus.alufun);

    // Compares always need a - b; arithmetic subtracts only for SUB
    assign w_sub = (w_class == ALU_CMP) || (aluBus.alufun[0] == OP_SUB[0]);

    mips_alu_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a    (aluBus.a),
        .i_b    (aluBus.b),
        .i_sub  (w_sub),
        .i_sign (aluBus.sign),
        .o_sum  (w_sum),
        .o_z    (w_z),
        .o_v    (w_v),
        .o_n    (w_n)
    );

    // V is already folded into N inside the adder; kept as a visible wire
    assign w_unusedFlags = w_v;

    // Bitwise logic, decoded on the low nibble of the function code
    always_comb begin
        w_logicRes = '0;
        case (aluBus.alufun[3:0])
            OP_AND[3:0]:   w_logicRes = aluBus.a & aluBus.b;
            OP_OR[3:0]:    w_logicRes = aluBus.a | aluBus.b;
            OP_XOR[3:0]:   w_logicRes = aluBus.a ^ aluBus.b;
            OP_NOR[3:0]:   w_logicRes = ~(aluBus.a | aluBus.b);
            OP_PASSA[3:0]: w_logicRes = aluBus.a;
            default:       w_logicRes = '0;
        endcase
    end

    // Shifter: b is shifted by a[4:0]; upper bits of a play no part
    assign w_shamt = aluBus.a[4:0];

    always_comb begin
        w_shiftRes = '0;
        case (aluBus.alufun[1:0])
            OP_SLL[1:0]: w_shiftRes = aluBus.b << w_shamt;
            OP_SRL[1:0]: w_shiftRes = aluBus.b >> w_shamt;
            OP_SRA[1:0]: w_shiftRes = $unsigned($signed(aluBus.b) >>> w_shamt);
            default:     w_shiftRes = '0;
        endcase
    end

    // Compare conditions; the against-zero forms always read a as signed,
    // matching the blez/bltz/bgtz branches. alufun[0] is a don't-care here.
    assign w_aZero = (aluBus.a == '0);

    always_comb begin
        w_cond = 1'b0;
        case (aluBus.alufun[3:1])
            OP_EQ[3:1]:  w_cond = w_z;
            OP_NEQ[3:1]: w_cond = ~w_z;
            OP_LT[3:1]:  w_cond = w_n;
            OP_LEZ[3:1]: w_cond = aluBus.a[WIDTH-1] | w_aZero;
            OP_LTZ[3:1]: w_cond = aluBus.a[WIDTH-1];
            OP_GTZ[3:1]: w_cond = ~aluBus.a[WIDTH-1] & ~w_aZero;
            default:     w_cond = 1'b0;
        endcase
    end

    // Class select feeding the result register
    always_comb begin
        w_next = '0;
        case (w_class)
            ALU_ARITH: w_next = w_sum;
            ALU_LOGIC: w_next = w_logicRes;
            ALU_SHIFT: w_next = w_shiftRes;
            ALU_CMP:   w_next = {{(WIDTH-1){1'b0}}, w_cond};
            default:   w_next = '0;
        endcase
    end

    // Result register: synchronous clear, otherwise capture every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res <= '0;
        end else begin
            r_res <= w_next;
        end
    end

    assign aluBus.res = r_res;

endmodule

// File: tb/tb_mips_alu.sv
// ---------------------------------------------------------------------------
// tb_mips_alu
// Directed, self-checking bench for mips_alu. Each feature has its own task
// with hand-computed expected results; outputs are sampled 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_mips_alu;
    import mips_alu_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  fun;
        logic        sgn;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   testsRun = 0;
    int   testsFailed = 0;

    mips_alu_if aluBus ();

    mips_alu dut (
        .clk    (clk),
        .reset  (reset),
        .aluBus (aluBus)
    );

    always #5 clk = ~clk;

    // Drive one operation on the falling edge, then step past the next rising edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [5:0] fun, input logic sgn);
        @(negedge clk);
        aluBus.a      = a;
        aluBus.b      = b;
        aluBus.alufun = fun;
        aluBus.sign   = sgn;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(32'hDEADBEEF, 32'h12345678, OP_ADD, 1'b1);
        testsRun++;
        if (aluBus.res !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_cycle1: res=%h expected=%h", aluBus.res, 32'h0);
        end
        applyStimulus(32'hFFFFFFFF, 32'h0F0F0F0F, OP_OR, 1'b0);
        testsRun++;
        if (aluBus.res !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_cycle2: res=%h expected=%h", aluBus.res, 32'h0);
        end
        reset = 1'b0;
        applyStimulus(32'd5, 32'd8, OP_ADD, 1'b1);
        testsRun++;
        if (aluBus.res !== 32'h0000000D) begin
            testsFailed++;
            $display("[TB] FAIL first_add: res=%h expected=%h", aluBus.res, 32'h0000000D);
        end
    endtask

    task automatic test_arith();
        vec_t vecs[4];
        vecs[0] = '{32'd5,        32'd8,        OP_SUB, 1'b1, 32'hFFFFFFFD, "sub_5_8"};
        vecs[1] = '{32'h7FFFFFFF, 32'd1,        OP_ADD, 1'b1, 32'h80000000, "add_wrap_signed"};
        vecs[2] = '{32'hFFFFFFFF, 32'd1,        OP_ADD, 1'b0, 32'h00000000, "add_wrap_unsigned"};
        vecs[3] = '{32'd0,        32'd1,        OP_SUB, 1'b0, 32'hFFFFFFFF, "sub_0_1"};
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].sgn);
            testsRun++;
            if (aluBus.res !== vecs[i].exp) begin
                testsFailed++;
                $display("[TB] FAIL %s: res=%h expected=%h", vecs[i].name, aluBus.res, vecs[i].exp);
            end
        end
    endtask

    task automatic test_logic();
        vec_t vecs[6];
        vecs[0] = '{32'd5, 32'd8, OP_AND,   1'b1, 32'h00000000, "and"};
        vecs[1] = '{32'd5, 32'd8, OP_OR,    1'b1, 32'h0000000D, "or"};
        vecs[2] = '{32'd5, 32'd8, OP_XOR,   1'b1, 32'h0000000D, "xor"};
        vecs[3] = '{32'd5, 32'd8, OP_NOR,   1'b1, 32'hFFFFFFF2, "nor"};
        vecs[4] = '{32'd5, 32'd8, OP_PASSA, 1'b1, 32'h00000005, "passa"};
        vecs[5] = '{32'hF0F0A5A5, 32'h0FF05A5A, OP_XOR, 1'b0, 32'hFF00FFFF, "xor_wide"};
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].sgn);
            testsRun++;
            if (aluBus.res !== vecs[i].exp) begin
                testsFailed++;
                $display("[TB] FAIL %s: res=%h expected=%h", vecs[i].name, aluBus.res, vecs[i].exp);
            end
        end
    endtask

    task automatic test_shift();
        vec_t vecs[9];
        vecs[0] = '{32'd5,  32'd8,        OP_SLL, 1'b1, 32'h00000100, "sll_5"};
        vecs[1] = '{32'd5,  32'd8,        OP_SRL, 1'b1, 32'h00000000, "srl_5"};
        vecs[2] = '{32'd5,  32'd8,        OP_SRA, 1'b1, 32'h00000000, "sra_5"};
        vecs[3] = '{32'd4,  32'h80000000, OP_SRA, 1'b1, 32'hF8000000, "sra_neg"};
        vecs[4] = '{32'd4,  32'h80000000, OP_SRL, 1'b1, 32'h08000000, "srl_neg"};
        vecs[5] = '{32'd0,  32'h89ABCDEF, OP_SRA, 1'b0, 32'h89ABCDEF, "sra_by0"};
        vecs[6] = '{32'd31, 32'h00000001, OP_SLL, 1'b0, 32'h80000000, "sll_by31"};
        vecs[7] = '{32'd31, 32'h80000000, OP_SRA, 1'b0, 32'hFFFFFFFF, "sra_by31"};
        vecs[8] = '{32'hFFFFFFE0, 32'h00001234, OP_SLL, 1'b0, 32'h00001234, "sll_upper_a_ignored"};
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].sgn);
            testsRun++;
            if (aluBus.res !== vecs[i].exp) begin
                testsFailed++;
                $display("[TB] FAIL %s: res=%h expected=%h", vecs[i].name, aluBus.res, vecs[i].exp);
            end
        end
    endtask

    task automatic test_compare();
        vec_t vecs[12];
        vecs[0]  = '{32'd5,        32'd8,      OP_EQ,    1'b1, 32'd0, "eq_5_8"};
        vecs[1]  = '{32'd5,        32'd8,      OP_NEQ,   1'b1, 32'd1, "neq_5_8"};
        vecs[2]  = '{32'd5,        32'd8,      OP_LT,    1'b1, 32'd1, "lt_5_8"};
        vecs[3]  = '{32'd5,        32'd8,      OP_LEZ,   1'b1, 32'd0, "lez_5"};
        vecs[4]  = '{32'd5,        32'd8,      OP_LTZ,   1'b1, 32'd0, "ltz_5"};
        vecs[5]  = '{32'd5,        32'd8,      OP_GTZ,   1'b1, 32'd1, "gtz_5"};
        vecs[6]  = '{32'd0,        32'd8,      OP_LEZ,   1'b1, 32'd1, "lez_0"};
        vecs[7]  = '{32'hFFFFFFFF, 32'd8,      OP_LTZ,   1'b1, 32'd1, "ltz_m1"};
        vecs[8]  = '{32'hFFFFFFFF, 32'd8,      OP_GTZ,   1'b0, 32'd0, "gtz_m1_unsigned_flag"};
        vecs[9]  = '{32'h00001234, 32'h1234,   OP_EQ,    1'b0, 32'd1, "eq_equal"};
        vecs[10] = '{32'd5,        32'd8,      6'b110100, 1'b1, 32'd1, "lt_bit0_ignored"};
        vecs[11] = '{32'hFFFFFFFF, 32'd8,      OP_LEZ,   1'b0, 32'd1, "lez_m1_unsigned_flag"};
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].sgn);
            testsRun++;
            if (aluBus.res !== vecs[i].exp) begin
                testsFailed++;
                $display("[TB] FAIL %s: res=%h expected=%h", vecs[i].name, aluBus.res, vecs[i].exp);
            end
        end
    endtask

    task automatic test_lt_boundary();
        vec_t vecs[5];
        vecs[0] = '{32'h80000000, 32'd1,        OP_LT, 1'b1, 32'd1, "lt_min_1_signed"};
        vecs[1] = '{32'h80000000, 32'd1,        OP_LT, 1'b0, 32'd0, "lt_min_1_unsigned"};
        vecs[2] = '{32'h7FFFFFFF, 32'hFFFFFFFF, OP_LT, 1'b1, 32'd0, "lt_ovf_signed"};
        vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, OP_LT, 1'b0, 32'd1, "lt_ovf_unsigned"};
        vecs[4] = '{32'd8,        32'd8,        OP_LT, 1'b1, 32'd0, "lt_equal"};
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].sgn);
            testsRun++;
            if (aluBus.res !== vecs[i].exp) begin
                testsFailed++;
                $display("[TB] FAIL %s: res=%h expected=%h", vecs[i].name, aluBus.res, vecs[i].exp);
            end
        end
    endtask

    task automatic test_undefined();
        vec_t vecs[4];
        vecs[0] = '{32'd5, 32'd8, 6'b011111, 1'b1, 32'd0, "undef_logic"};
        vecs[1] = '{32'd5, 32'd8, 6'b100010, 1'b1, 32'd0, "undef_shift"};
        vecs[2] = '{32'd5, 32'd5, 6'b110111, 1'b1, 32'd0, "undef_cmp"};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 6'b010000, 1'b0, 32'd0, "undef_logic0"};
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].sgn);
            testsRun++;
            if (aluBus.res !== vecs[i].exp) begin
                testsFailed++;
                $display("[TB] FAIL %s: res=%h expected=%h", vecs[i].name, aluBus.res, vecs[i].exp);
            end
        end
    endtask

    // New op every cycle: before the edge res must still hold the previous
    // op's result, right after the edge it must hold the current one.
    task automatic test_back_to_back();
        vec_t vecs[6];
        vecs[0] = '{32'd1,        32'd2,   OP_ADD, 1'b1, 32'h00000003, "b2b_add"};
        vecs[1] = '{32'd1,        32'd3,   OP_SLL, 1'b1, 32'h00000006, "b2b_sll"};
        vecs[2] = '{32'h000000F0, 32'hFF,  OP_XOR, 1'b1, 32'h0000000F, "b2b_xor"};
        vecs[3] = '{32'd3,        32'd2,   OP_LT,  1'b0, 32'h00000000, "b2b_lt"};
        vecs[4] = '{32'd0,        32'd0,   OP_NOR, 1'b0, 32'hFFFFFFFF, "b2b_nor"};
        vecs[5] = '{32'd10,       32'd3,   OP_SUB, 1'b1, 32'h00000007, "b2b_sub"};
        foreach (vecs[i]) begin
            @(negedge clk);
            aluBus.a      = vecs[i].a;
            aluBus.b      = vecs[i].b;
            aluBus.alufun = vecs[i].fun;
            aluBus.sign   = vecs[i].sgn;
            #1;
            if (i > 0) begin
                testsRun++;
                if (aluBus.res !== vecs[i-1].exp) begin
                    testsFailed++;
                    $display("[TB] FAIL %s_hold: res=%h expected=%h", vecs[i].name, aluBus.res, vecs[i-1].exp);
                end
            end
            @(posedge clk);
            #1;
            testsRun++;
            if (aluBus.res !== vecs[i].exp) begin
                testsFailed++;
                $display("[TB] FAIL %s: res=%h expected=%h", vecs[i].name, aluBus.res, vecs[i].exp);
            end
        end
    endtask

    task automatic test_reset_midstream();
        applyStimulus(32'd5, 32'd8, OP_ADD, 1'b1);
        testsRun++;
        if (aluBus.res !== 32'h0000000D) begin
            testsFailed++;
            $display("[TB] FAIL mid_before: res=%h expected=%h", aluBus.res, 32'h0000000D);
        end
        reset = 1'b1;
        applyStimulus(32'd5, 32'd8, OP_OR, 1'b1);
        testsRun++;
        if (aluBus.res !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset: res=%h expected=%h", aluBus.res, 32'h0);
        end
        reset = 1'b0;
        applyStimulus(32'd5, 32'd8, OP_SUB, 1'b1);
        testsRun++;
        if (aluBus.res !== 32'hFFFFFFFD) begin
            testsFailed++;
            $display("[TB] FAIL mid_after: res=%h expected=%h", aluBus.res, 32'hFFFFFFFD);
        end
    endtask

    initial begin
        reset         = 1'b1;
        aluBus.a      = '0;
        aluBus.b      = '0;
        aluBus.alufun = OP_ADD;
        aluBus.sign   = 1'b0;
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_compare();
        test_lt_boundary();
        test_undefined();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
